// File: rtl/iob_ram_dp_be_fifo_ctrl.sv
// First-word-fall-through FIFO controller for an external dual-port byte-enable RAM (1-cycle read).
// Optional macro IOB_RAM_DP_BE_FIFO_CTRL_LEVEL_EN adds registered level_o / almost_full_o ports.

module iob_ram_dp_be_fifo_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int AFULL_THR = (2 ** ADDR_W) - 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                w_valid_i,
    output logic                w_ready_o,
    input  logic [DATA_W-1:0]   w_data_i,
    output logic                r_valid_o,
    input  logic                r_ready_i,
    output logic [DATA_W-1:0]   r_data_o,
    output logic                ram_enA_o,
    output logic [DATA_W/8-1:0] ram_weA_o,
    output logic [ADDR_W-1:0]   ram_addrA_o,
    output logic [DATA_W-1:0]   ram_dA_o,
    output logic                ram_enB_o,
    output logic [DATA_W/8-1:0] ram_weB_o,
    output logic [ADDR_W-1:0]   ram_addrB_o,
    output logic [DATA_W-1:0]   ram_dB_o,
`ifdef IOB_RAM_DP_BE_FIFO_CTRL_LEVEL_EN
    output logic [ADDR_W+1:0]   level_o,
    output logic                almost_full_o,
`endif
    input  logic [DATA_W-1:0]   ram_dB_i
);

    localparam int BE_W = DATA_W / 8;
    localparam int PW   = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(2 ** ADDR_W);

    logic [PW-1:0]            wptr, rptr, wptrNext, rptrNext, ramCntNext;
    logic                     wReady, inflight;
    logic                     wAccept, pop, issue;
    logic [1:0]               occ, occAfterPop, occNext;
    logic [2:0]               occAdj;
    logic [1:0][DATA_W-1:0]   obuf;

    assign wAccept = w_valid_i & wReady;
    assign pop     = (occ != 2'd0) & r_ready_i;

    // Issue only while the buffer slots (occupied + returning) stay below two after this pop.
    assign occAfterPop = occ - {1'b0, pop};
    assign occAdj      = {1'b0, occAfterPop} + {2'b0, inflight};
    assign issue       = (wptr != rptr) && (occAdj < 3'd2);
    assign occNext     = occAdj[1:0];

    assign wptrNext   = wptr + PW'(wAccept);
    assign rptrNext   = rptr + PW'(issue);
    assign ramCntNext = wptrNext - rptrNext;

    assign w_ready_o = wReady;
    assign r_valid_o = (occ != 2'd0);
    assign r_data_o  = obuf[0];

    assign ram_enA_o   = wAccept;
    assign ram_weA_o   = {BE_W{wAccept}};
    assign ram_addrA_o = wptr[ADDR_W-1:0];
    assign ram_dA_o    = w_data_i;

    assign ram_enB_o   = issue;
    assign ram_weB_o   = '0;
    assign ram_addrB_o = rptr[ADDR_W-1:0];
    assign ram_dB_o    = '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr     <= '0;
            rptr     <= '0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            wReady   <= 1'b1;
            obuf     <= '0;
        end else begin
            wptr     <= wptrNext;
            rptr     <= rptrNext;
            occ      <= occNext;
            inflight <= issue;
            wReady   <= (ramCntNext != DEPTH_P);
            if (pop)
                obuf[0] <= obuf[1];
            // Returning word lands behind whatever survives this cycle's pop.
            if (inflight)
                obuf[occAfterPop[0]] <= ram_dB_i;
        end
    end

`ifdef IOB_RAM_DP_BE_FIFO_CTRL_LEVEL_EN
    localparam int LW = ADDR_W + 2;
    logic [LW-1:0] levelNext;

    assign levelNext = LW'(ramCntNext) + LW'(issue) + LW'(occNext);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_o       <= '0;
            almost_full_o <= 1'b0;
        end else begin
            level_o       <= levelNext;
            almost_full_o <= (levelNext >= LW'(AFULL_THR));
        end
    end
`endif

endmodule

// File: tb/tb_iob_ram_dp_be_fifo_ctrl.sv
// Bench for iob_ram_dp_be_fifo_ctrl: behavioural RAM plus queue scoreboard, directed and random scenarios.
// Level/almost-full checks are compiled only when IOB_RAM_DP_BE_FIFO_CTRL_LEVEL_EN is defined.

module tb_iob_ram_dp_be_fifo_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int BE    = DW / 8;

    logic          clk = 1'b0;
    logic          rst, wValid, wReady, rValid, rReady;
    logic [DW-1:0] wData, rData;
    logic          enA, enB;
    logic [BE-1:0] weA, weB;
    logic [AW-1:0] addrA, addrB;
    logic [DW-1:0] dA, dBo, dBq;
`ifdef IOB_RAM_DP_BE_FIFO_CTRL_LEVEL_EN
    logic [AW+1:0] level;
    logic          aFull;
`endif

    always #5 clk = ~clk;

    iob_ram_dp_be_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .w_valid_i(wValid), .w_ready_o(wReady), .w_data_i(wData),
        .r_valid_o(rValid), .r_ready_i(rReady), .r_data_o(rData),
        .ram_enA_o(enA), .ram_weA_o(weA), .ram_addrA_o(addrA), .ram_dA_o(dA),
        .ram_enB_o(enB), .ram_weB_o(weB), .ram_addrB_o(addrB), .ram_dB_o(dBo),
`ifdef IOB_RAM_DP_BE_FIFO_CTRL_LEVEL_EN
        .level_o(level), .almost_full_o(aFull),
`endif
        .ram_dB_i(dBq)
    );

    // Dual-port byte-enable RAM, registered read on port B
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (enA)
            for (int b = 0; b < BE; b++)
                if (weA[b]) mem[addrA][b*8 +: 8] <= dA[b*8 +: 8];
        if (enB) dBq <= mem[addrB];
    end

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] q[$];

    logic          sAcc, sPop, sWr, sRv, sEnA, sEnB, sColl;
    logic [BE-1:0] sWeA;
    logic [DW-1:0] sData, sExp;
    int            sSize;
    logic [AW+1:0] sLevel;
    logic          sAf;

    // One clock: drive after negedge, sample, then update the scoreboard at the edge.
    task automatic cyc(input logic r, input logic wv, input logic [DW-1:0] wd, input logic rr);
        @(negedge clk);
        rst = r; wValid = wv; wData = wd; rReady = rr;
        #1;
        sWr = wReady; sRv = rValid; sData = rData; sEnA = enA; sEnB = enB; sWeA = weA;
        sColl = enA && enB && (addrA == addrB);
        sAcc = wv && wReady;
        sPop = rValid && rr;
        sSize = q.size();
        sExp = (q.size() > 0) ? q[0] : 32'hDEAD_BEEF;
`ifdef IOB_RAM_DP_BE_FIFO_CTRL_LEVEL_EN
        sLevel = level; sAf = aFull;
`else
        sLevel = '0; sAf = 1'b0;
`endif
        @(posedge clk);
        if (r) q.delete();
        else begin
            if (sPop && q.size() > 0) void'(q.pop_front());
            if (sAcc) q.push_back(wd);
        end
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset_latency();
        do_reset();
        cyc(1'b0, 1'b0, '0, 1'b0);
        total++; if (sWr !== 1'b1) begin bad++; $display("FAIL reset_wready got=%0b want=1", sWr); end
        total++; if (sRv !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0b want=0", sRv); end
        total++; if (sData !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", sData); end
        total++; if ({sEnA, sEnB, sWeA} !== '0) begin bad++; $display("FAIL reset_ram_en got=%b want=0", {sEnA, sEnB, sWeA}); end
`ifdef IOB_RAM_DP_BE_FIFO_CTRL_LEVEL_EN
        total++; if (sLevel !== '0 || sAf !== 1'b0) begin bad++; $display("FAIL reset_level got=%0d/%0b want=0/0", sLevel, sAf); end
`endif
        cyc(1'b0, 1'b1, 32'h11, 1'b0);
        total++; if (!(sAcc && sEnA && sWeA == 4'hF)) begin bad++; $display("FAIL first_write acc=%0b en=%0b we=%h want 1,1,f", sAcc, sEnA, sWeA); end
        // First edge at which the word is poppable must be write edge + 3.
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0, 1'b0, '0, 1'b0);
            if (k == 1) begin
                total++; if (sEnB !== 1'b1) begin bad++; $display("FAIL issue_after_write got=%0b want=1", sEnB); end
            end
            total++; if (sRv !== (k == 3)) begin bad++; $display("FAIL fall_through_k%0d got=%0b want=%0b", k, sRv, (k == 3)); end
        end
        total++; if (sData !== 32'h11) begin bad++; $display("FAIL first_word got=%h want=11", sData); end
        cyc(1'b0, 1'b0, '0, 1'b1);
        total++; if (!sPop || sData !== sExp) begin bad++; $display("FAIL first_pop pop=%0b got=%h want=%h", sPop, sData, sExp); end
        cyc(1'b0, 1'b0, '0, 1'b0);
        total++; if (sRv !== 1'b0) begin bad++; $display("FAIL empty_after_pop got=%0b want=0", sRv); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, DW'(i), 1'b0);
            total++; if (sAcc !== 1'b1) begin bad++; $display("FAIL fill_accept_%0d got=%0b want=1", i, sAcc); end
        end
        cyc(1'b0, 1'b1, 32'd10, 1'b0);
        total++; if (sWr !== 1'b0 || sAcc !== 1'b0) begin bad++; $display("FAIL full_reject wready=%0b acc=%0b want 0,0", sWr, sAcc); end
        total++; if (sSize != DEPTH + 2) begin bad++; $display("FAIL full_size got=%0d want=%0d", sSize, DEPTH + 2); end
`ifdef IOB_RAM_DP_BE_FIFO_CTRL_LEVEL_EN
        total++; if (int'(sLevel) != sSize || sAf !== 1'b1) begin bad++; $display("FAIL full_level got=%0d/%0b want=%0d/1", sLevel, sAf, sSize); end
`endif
    endtask

    task automatic test_drain();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, '0, 1'b1);
            total++; if (!sPop || sData !== DW'(i) || sData !== sExp) begin bad++; $display("FAIL drain_%0d pop=%0b got=%h want=%h", i, sPop, sData, i); end
            if (i == 0) begin
                total++; if (sWr !== 1'b0 || sEnB !== 1'b1) begin bad++; $display("FAIL drain_first_issue wready=%0b enB=%0b want 0,1", sWr, sEnB); end
            end
            if (i == 1) begin
                total++; if (sWr !== 1'b1) begin bad++; $display("FAIL drain_wready_back got=%0b want=1", sWr); end
            end
        end
        cyc(1'b0, 1'b0, '0, 1'b1);
        total++; if (sRv !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0b want=0", sRv); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 45; c++) begin
            cyc(1'b0, (c < 40), DW'(c), 1'b1);
            if (c < 40) begin
                total++; if (sAcc !== 1'b1) begin bad++; $display("FAIL stream_accept_%0d got=%0b want=1", c, sAcc); end
            end
            total++;
            if (sPop !== (c >= 3 && c < 43) || (sPop && sData !== DW'(c - 3))) begin
                bad++; $display("FAIL stream_pop_%0d pop=%0b data=%h want pop=%0b data=%h", c, sPop, sData, (c >= 3 && c < 43), c - 3);
            end
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int got  = 0;
        int n    = 0;
        logic wv, rr;
        do_reset();
        while (got < 1000 && n < 20000) begin
            wv = (sent < 1000) && ($urandom_range(0, 1) == 1);
            rr = ($urandom_range(0, 1) == 1);
            cyc(1'b0, wv, $urandom, rr);
            n++;
            if (sAcc) begin
                sent++;
                total++; if (sSize >= DEPTH + 2) begin bad++; $display("FAIL rand_overflow size=%0d want<%0d", sSize, DEPTH + 2); end
            end
            if (!sWr) begin
                total++; if (sSize < DEPTH) begin bad++; $display("FAIL rand_wready_low size=%0d want>=%0d", sSize, DEPTH); end
            end
            if (sRv) begin
                total++; if (sSize == 0) begin bad++; $display("FAIL rand_valid_empty got=1 want=0"); end
            end
            if (sPop) begin
                got++;
                total++; if (sData !== sExp) begin bad++; $display("FAIL rand_order_%0d got=%h want=%h", got, sData, sExp); end
            end
            if (sEnA && sEnB) begin
                total++; if (sColl) begin bad++; $display("FAIL rand_addr_collision got=%0d want!=%0d", addrB, addrA); end
            end
`ifdef IOB_RAM_DP_BE_FIFO_CTRL_LEVEL_EN
            total++; if (int'(sLevel) != sSize || sAf !== (sSize >= DEPTH - 4)) begin bad++; $display("FAIL rand_level got=%0d/%0b want=%0d", sLevel, sAf, sSize); end
`endif
        end
        total++; if (got != 1000) begin bad++; $display("FAIL rand_timeout got=%0d want=1000", got); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, DW'(100 + i), 1'b0);
        repeat (3) cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        total++; if (!sPop || sData !== 32'd100) begin bad++; $display("FAIL midop_pop pop=%0b got=%h want=64", sPop, sData); end
        // Reset with a read in flight and another issuing this cycle.
        cyc(1'b1, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0);
        total++; if (sRv !== 1'b0 || sWr !== 1'b1) begin bad++; $display("FAIL midop_reset rvalid=%0b wready=%0b want 0,1", sRv, sWr); end
`ifdef IOB_RAM_DP_BE_FIFO_CTRL_LEVEL_EN
        total++; if (sLevel !== '0) begin bad++; $display("FAIL midop_level got=%0d want=0", sLevel); end
`endif
        cyc(1'b0, 1'b0, '0, 1'b0);
        total++; if (sRv !== 1'b0) begin bad++; $display("FAIL midop_stale_capture got=%0b want=0", sRv); end
        cyc(1'b0, 1'b1, 32'hABC, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        total++; if (!sPop || sData !== 32'hABC) begin bad++; $display("FAIL midop_fresh pop=%0b got=%h want=abc", sPop, sData); end
    endtask

    initial begin
        rst = 1'b1; wValid = 1'b0; wData = '0; rReady = 1'b0;
        test_reset_latency();
        test_fill();
        test_drain();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
